output_buffer_ctrl: RTL and testbench
=====================================

OUTPUT_BUFFER_CTRL -- requirements
Module: output_buffer_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port i_result_vec, input, `ARRAY_COL*8: one quantized array output row (16 cols x int8, col0 in bits [7:0]).
REQ-004 SHALL have port i_result_valid, input, 1: write i_result_vec this cycle.
REQ-005 SHALL have port i_tile_done, input, 1: commit fill bank for draining.
REQ-006 SHALL have port o_swap_ready, output, 1: drain side idle; i_tile_done accepted.
REQ-007 SHALL have port o_overflow, output, 1: sticky error flag.
REQ-008 SHALL have ports m_axis_tdata (output, 64), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1): AXI-Stream master to DMA.

Function
REQ-009 SHALL hold two banks of 16 x 128-bit rows (ping-pong); one bank fills, the other drains.
REQ-010 SHALL write i_result_vec to fill bank at wr_ptr and increment wr_ptr on each i_result_valid while wr_ptr < 16.
REQ-011 SHALL drop writes when wr_ptr == 16 (fill bank full) and set o_overflow.
REQ-012 SHALL, on i_tile_done with o_swap_ready high: swap banks, latch row count = wr_ptr, clear wr_ptr to 0, start drain.
REQ-013 SHALL, when i_result_valid and i_tile_done coincide, include that row in the committed tile (count includes it).
REQ-014 SHALL ignore i_tile_done when o_swap_ready is low, set o_overflow, keep fill bank contents and wr_ptr.
REQ-015 SHALL treat a committed count of 0 as an empty tile: no beats, drain stays IDLE.
REQ-016 SHALL drain with FSM IDLE -> LOAD -> SEND_LO -> SEND_HI -> (SEND_LO of next row | IDLE after last row).
REQ-017 SHALL emit each row as two beats, low 64 bits (SEND_LO) then high 64 bits (SEND_HI).
REQ-018 SHALL assert first m_axis_tvalid in cycle T+2 for i_tile_done in cycle T.
REQ-019 SHALL advance a beat only on m_axis_tvalid && m_axis_tready; tdata/tlast stable while tvalid && !tready.
REQ-020 SHALL never deassert m_axis_tvalid before handshake once asserted.
REQ-021 SHALL sustain one beat per cycle with m_axis_tready held high: N rows drain in exactly 2N consecutive cycles (next-row prefetch, no bubble).
REQ-022 SHALL drive o_swap_ready high only in IDLE; it rises the cycle after the final beat handshakes.
REQ-023 SHALL allow filling the fill bank at full rate during draining, independent of backpressure.
REQ-024 SHALL clear o_overflow only by reset.

Reset
REQ-025 SHALL, on rst_n low (including mid-drain), force: m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, o_overflow 0, o_swap_ready 1, FSM IDLE, bank select 0, wr_ptr 0, row count 0; RAM contents not reset.

Configuration
REQ-026 SHALL, with OBUF_TLAST_EN defined, assert m_axis_tlast on the SEND_HI beat of the last row of each tile.
REQ-027 SHALL, without OBUF_TLAST_EN, keep the m_axis_tlast port and tie it to 0.

Structure
REQ-028 SHALL take ARRAY_COL from shared params.vh; bank depth log2 (4) and beat width (64) SHALL be local constants.
REQ-029 SHALL infer RAM (2 x 16 x 128, LUTRAM) inline; one optional sub-module obuf_gearbox_tx (128->64 beat sequencer with skid hold) is natural.

Verification
REQ-030 SHALL cover: write 12 rows (row k = bytes all k), i_tile_done, tready=1 -> 24 beats in cycles T+2..T+25, beat 2k = low half of row k, tlast only on beat 23.
REQ-031 SHALL cover: tready toggling 1,0,0,1 during 4-row drain -> 8 beats, tdata held across stalls, no beat lost or duplicated.
REQ-032 SHALL cover: 17 writes before i_tile_done -> 16 rows drained (32 beats), o_overflow=1.
REQ-033 SHALL cover: second i_tile_done during drain -> ignored, o_overflow=1, second tile drained intact after a later accepted i_tile_done.
REQ-034 SHALL cover: i_tile_done with 0 rows -> no tvalid, o_swap_ready stays 1; i_result_valid coincident with i_tile_done after 3 rows -> 4 rows (8 beats).
REQ-035 SHALL cover: rst_n pulsed low mid-drain -> tvalid 0 immediately, o_overflow 0, next tile drains from bank 0 correctly.

Source files
------------

// File: rtl/output_buffer_ctrl_pkg.sv
// Shared constants and types for the output buffer controller.
// The row width follows the systolic array column count (ARRAY_COL, int8 per
// column). The optional OBUF_TLAST_EN macro enables end-of-tile TLAST marking.
package output_buffer_ctrl_pkg;

  localparam int ARRAY_COL  = 16;              // systolic array columns

  localparam int ROW_W      = ARRAY_COL * 8;   // one quantized array row
  localparam int BEAT_W     = 64;              // AXI-Stream beat width
  localparam int DEPTH_LOG2 = 4;               // rows per bank, log2
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int CNT_W      = DEPTH_LOG2 + 1;  // must hold DEPTH itself

`ifdef OBUF_TLAST_EN
  localparam bit TLAST_EN   = 1'b1;
`else
  localparam bit TLAST_EN   = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SEND_LO = 2'd2,
    ST_SEND_HI = 2'd3
  } drain_state_e;

endpackage

// File: rtl/output_buffer_ctrl_gearbox_tx.sv
// obuf_gearbox_tx: drains a committed tile from the drain bank, splitting each
// 128-bit row into a low and a high 64-bit AXI-Stream beat. The high half is
// held locally so the RAM read port is free to prefetch the next row while the
// high beat is on the bus, giving one beat per cycle with no inter-row bubble.
// With OBUF_TLAST_EN the high beat of the last row carries tlast; otherwise
// tlast stays 0.
module obuf_gearbox_tx
  import output_buffer_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      count_i,
  input  logic [ROW_W-1:0]      rd_data_i,
  output logic [DEPTH_LOG2-1:0] rd_addr_o,
  output logic [BEAT_W-1:0]     tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
  output logic                  idle_o
);

  drain_state_e          state_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BEAT_W-1:0]     hi_q;
  logic [BEAT_W-1:0]     tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  last_row;

  assign last_row  = (CNT_W'(rd_ptr_q) + CNT_W'(1)) == cnt_q;
  // While the high beat is presented, address the next row so it is ready
  // the moment that beat handshakes.
  assign rd_addr_o = (state_q == ST_SEND_HI) ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
  assign idle_o    = (state_q == ST_IDLE);
  assign tdata_o   = tdata_q;
  assign tvalid_o  = tvalid_q;
  assign tlast_o   = tlast_q;

  // Drain FSM with registered AXI-Stream outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          if (start_i) begin
            cnt_q    <= count_i;
            rd_ptr_q <= '0;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tdata_q  <= rd_data_i[BEAT_W-1:0];
          hi_q     <= rd_data_i[2*BEAT_W-1:BEAT_W];
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b0;
          state_q  <= ST_SEND_LO;
        end
        ST_SEND_LO: begin
          if (tready_i) begin
            tdata_q <= hi_q;
            tlast_q <= TLAST_EN && last_row;
            state_q <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          if (tready_i) begin
            if (last_row) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
              tdata_q  <= rd_data_i[BEAT_W-1:0];
              hi_q     <= rd_data_i[2*BEAT_W-1:BEAT_W];
              tlast_q  <= 1'b0;
              state_q  <= ST_SEND_LO;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/output_buffer_ctrl.sv
// output_buffer_ctrl: ping-pong buffer between the systolic array and the DMA.
// One bank collects quantized result rows while the other is streamed out as
// 64-bit AXI-Stream beats by obuf_gearbox_tx. Overflow (row written to a full
// bank, or a tile committed while the drain is busy) raises a sticky flag.
// Optional feature macro: OBUF_TLAST_EN (mark last beat of each tile).
module output_buffer_ctrl
  import output_buffer_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  i_result_vec,
  input  logic              i_result_valid,
  input  logic              i_tile_done,
  output logic              o_swap_ready,
  output logic              o_overflow,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  logic [ROW_W-1:0]      mem_q [2][DEPTH];
  logic                  bank_sel_q, bank_sel_d;   // bank currently filling
  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  ovf_q, ovf_d;

  logic                  fill_full;
  logic                  wr_en;
  logic                  accept;
  logic                  start;
  logic [CNT_W-1:0]      commit_cnt;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [ROW_W-1:0]      rd_data;
  logic                  drain_idle;

  assign fill_full  = (wr_ptr_q == CNT_W'(DEPTH));
  assign wr_en      = i_result_valid && !fill_full;
  assign accept     = i_tile_done && drain_idle;
  // A row written in the commit cycle belongs to the committed tile.
  assign commit_cnt = wr_ptr_q + CNT_W'(wr_en);
  assign start      = accept && (commit_cnt != '0);

  // Fill-side next state: write pointer, bank swap and sticky overflow.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bank_sel_d = bank_sel_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_q;
    if (wr_en)
      wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (i_result_valid && fill_full)
      ovf_d = 1'b1;
    if (i_tile_done && !drain_idle)
      ovf_d = 1'b1;
    if (accept) begin
      bank_sel_d = !bank_sel_q;
      wr_ptr_d   = '0;
    end
  end

  // Fill-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q <= 1'b0;
      wr_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Row storage write port into the fill bank.
  // NOTE: the RAM has no reset so it maps onto LUTRAM; stale contents are
  // never read because only committed rows are drained.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[bank_sel_q][wr_ptr_q[DEPTH_LOG2-1:0]] <= i_result_vec;
  end

  // Asynchronous read of the drain bank (the one not filling).
  assign rd_data = mem_q[!bank_sel_q][rd_addr];

  obuf_gearbox_tx u_gearbox (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .count_i   (commit_cnt),
    .rd_data_i (rd_data),
    .rd_addr_o (rd_addr),
    .tdata_o   (m_axis_tdata),
    .tvalid_o  (m_axis_tvalid),
    .tready_i  (m_axis_tready),
    .tlast_o   (m_axis_tlast),
    .idle_o    (drain_idle)
  );

  assign o_swap_ready = drain_idle;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Self-checking bench for output_buffer_ctrl. A transaction-level model keeps
// the rows written to the fill side and, on every accepted commit, the exact
// list of beats the DMA must receive; DUT outputs are compared each cycle.
module tb_output_buffer_ctrl;
  import output_buffer_ctrl_pkg::*;

`ifdef OBUF_TLAST_EN
  localparam bit TLAST = 1'b1;
`else
  localparam bit TLAST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ROW_W-1:0]  i_result_vec;
  logic              i_result_valid;
  logic              i_tile_done;
  logic              o_swap_ready;
  logic              o_overflow;
  logic [BEAT_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  output_buffer_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_result_vec   (i_result_vec),
    .i_result_valid (i_result_valid),
    .i_tile_done    (i_tile_done),
    .o_swap_ready   (o_swap_ready),
    .o_overflow     (o_overflow),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic              tl;
  } beat_t;

  beat_t            exp_q[$];    // beats still owed to the DMA
  logic [ROW_W-1:0] fill_q[$];   // rows held in the fill bank
  bit               exp_ovf;
  int               cyc;
  int               acc_cyc;     // cycle of last accepted non-empty commit
  int               dut_hs;      // handshakes seen on the DUT bus
  int               dut_last_hs;
  int               checks;
  int               errors;

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model by what the next rising edge does.
  task automatic tick(input logic v, input logic [ROW_W-1:0] d, input logic td, input logic rdy);
    bit ready_now;
    bit tv_exp;
    i_result_valid = v;
    i_result_vec   = d;
    i_tile_done    = td;
    m_axis_tready  = rdy;
    @(negedge clk);
    ready_now = (exp_q.size() == 0);
    tv_exp    = !ready_now && (cyc >= acc_cyc + 2);
    check("swap_ready", ROW_W'(o_swap_ready), ROW_W'(ready_now));
    check("overflow", ROW_W'(o_overflow), ROW_W'(exp_ovf));
    check("tvalid", ROW_W'(m_axis_tvalid), ROW_W'(tv_exp));
    if (tv_exp) begin
      check("tdata", ROW_W'(m_axis_tdata), ROW_W'(exp_q[0].data));
      check("tlast", ROW_W'(m_axis_tlast), ROW_W'(exp_q[0].tl));
    end else begin
      check("tlast_idle", ROW_W'(m_axis_tlast), '0);
    end
    if (m_axis_tvalid === 1'b1 && rdy) begin
      dut_hs++;
      dut_last_hs = cyc;
    end
    if (tv_exp && rdy) void'(exp_q.pop_front());
    if (v) begin
      if (fill_q.size() < DEPTH) fill_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    if (td) begin
      if (!ready_now) begin
        exp_ovf = 1'b1;
      end else begin
        if (fill_q.size() > 0) acc_cyc = cyc;
        foreach (fill_q[i]) begin
          exp_q.push_back('{fill_q[i][BEAT_W-1:0], 1'b0});
          exp_q.push_back('{fill_q[i][2*BEAT_W-1:BEAT_W], TLAST && (i == fill_q.size() - 1)});
        end
        fill_q.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run idle cycles until every owed beat is taken; mode 0: tready high,
  // 1: tready pattern 1,0,0,1, 2: random tready.
  task automatic drain(input int mode, input int budget);
    int  n;
    logic rdy;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 4 == 0) || (n % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tick(1'b0, '0, 1'b0, rdy);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    i_result_valid = 1'b0;
    i_tile_done    = 1'b0;
    m_axis_tready  = 1'b0;
    i_result_vec   = '0;
    rst_n          = 1'b0;
    #1;
    check("rst_tvalid", ROW_W'(m_axis_tvalid), '0);
    check("rst_tlast", ROW_W'(m_axis_tlast), '0);
    check("rst_tdata", ROW_W'(m_axis_tdata), '0);
    check("rst_overflow", ROW_W'(o_overflow), '0);
    check("rst_swap_ready", ROW_W'(o_swap_ready), ROW_W'(1'b1));
    exp_q.delete();
    fill_q.delete();
    exp_ovf = 1'b0;
    acc_cyc = -100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t0;
    int h0;
    checks = 0;
    errors = 0;
    cyc    = 0;
    dut_hs = 0;
    dut_last_hs = 0;
    do_reset();

    // 12 rows of constant bytes, full-rate drain: 24 beats in T+2..T+25.
    for (int k = 0; k < 12; k++) tick(1'b1, {16{8'(k)}}, 1'b0, 1'b1);
    t0 = cyc;
    h0 = dut_hs;
    tick(1'b0, '0, 1'b1, 1'b1);
    drain(0, 60);
    check("a_beats", ROW_W'(dut_hs - h0), ROW_W'(24));
    check("a_last_beat_cycle", ROW_W'(dut_last_hs), ROW_W'(t0 + 25));

    // 4 random rows drained under a 1,0,0,1 tready pattern.
    for (int k = 0; k < 4; k++) tick(1'b1, rand_row(), 1'b0, 1'b0);
    h0 = dut_hs;
    tick(1'b0, '0, 1'b1, 1'b0);
    drain(1, 60);
    check("b_beats", ROW_W'(dut_hs - h0), ROW_W'(8));

    // 17 writes into a 16-row bank: one dropped, overflow sticks.
    for (int k = 0; k < 17; k++) tick(1'b1, rand_row(), 1'b0, 1'b1);
    h0 = dut_hs;
    tick(1'b0, '0, 1'b1, 1'b1);
    drain(0, 80);
    check("c_beats", ROW_W'(dut_hs - h0), ROW_W'(32));
    check("c_overflow", ROW_W'(o_overflow), ROW_W'(1'b1));

    // Commit while draining is ignored; the second tile survives intact.
    do_reset();
    for (int k = 0; k < 3; k++) tick(1'b1, rand_row(), 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, rand_row(), 1'b0, 1'($urandom_range(0, 1)));
    tick(1'b0, '0, 1'b1, 1'b1);
    check("d_overflow", ROW_W'(o_overflow), ROW_W'(1'b1));
    drain(2, 100);
    h0 = dut_hs;
    tick(1'b0, '0, 1'b1, 1'b1);
    drain(2, 100);
    check("d_second_tile_beats", ROW_W'(dut_hs - h0), ROW_W'(10));

    // Empty commit, then a row coincident with the commit.
    do_reset();
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b1, rand_row(), 1'b0, 1'b1);
    h0 = dut_hs;
    tick(1'b1, rand_row(), 1'b1, 1'b1);
    drain(0, 40);
    check("e_beats", ROW_W'(dut_hs - h0), ROW_W'(8));

    // Reset in the middle of a drain, then a fresh tile from bank 0.
    for (int k = 0; k < 6; k++) tick(1'b1, rand_row(), 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0, '0, 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < 2; k++) tick(1'b1, rand_row(), 1'b0, 1'b1);
    h0 = dut_hs;
    tick(1'b0, '0, 1'b1, 1'b1);
    drain(0, 40);
    check("f_beats", ROW_W'(dut_hs - h0), ROW_W'(4));

    // Random traffic: fill, commits and backpressure all mixed.
    do_reset();
    for (int k = 0; k < 600; k++)
      tick(1'($urandom_range(0, 1)), rand_row(), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0));
    drain(2, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
